// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the core and the MUL AB / DIV AB sequencer.
// The core is the master: it issues the request and consumes results and flags.
interface muldiv_seq_if;
  logic       start;
  logic       op;
  logic [7:0] acc_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] acc_out;
  logic [7:0] b_out;
  logic       cy_out;
  logic       ov_out;
  logic       flag_we;

  modport master (
    output start, op, acc_in, b_in,
    input  busy, done, acc_out, b_out, cy_out, ov_out, flag_we
  );

  modport slave (
    input  start, op, acc_in, b_in,
    output busy, done, acc_out, b_out, cy_out, ov_out, flag_we
  );
endinterface

// File: rtl/muldiv_seq.sv
// 8051 MUL AB / DIV AB sequencer: 8-iteration shift-add multiply or restoring divide,
// returning ACC/B results plus CY/OV and a one-cycle flag-write strobe.
module muldiv_seq (
  input  logic         clock,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [2:0] cnt_r;
  logic       op_r;
  logic [7:0] opnd_r;   // multiplicand (MUL) or divisor (DIV)
  logic [7:0] hi_r;     // product high byte (MUL) or partial remainder (DIV)
  logic [7:0] lo_r;     // multiplier being consumed (MUL) or quotient (DIV)
  logic       busy_r;
  logic       done_r;
  logic       cy_r;
  logic       ov_r;
  logic [7:0] acc_out_r;
  logic [7:0] b_out_r;

  logic [8:0] sum_s;
  logic [9:0] trial_s;
  logic [7:0] hi_nxt_s;
  logic [7:0] lo_nxt_s;

  // One iteration of the datapath for the current op.
  always_comb begin
    sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : 9'd0);
    trial_s  = {1'b0, hi_r, lo_r[7]} - {2'b00, opnd_r};
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (op_r == 1'b0) begin
      hi_nxt_s = sum_s[8:1];
      lo_nxt_s = {sum_s[0], lo_r[7:1]};
    end else if (trial_s[9] == 1'b0) begin
      hi_nxt_s = trial_s[7:0];
      lo_nxt_s = {lo_r[6:0], 1'b1};
    end else begin
      hi_nxt_s = {hi_r[6:0], lo_r[7]};
      lo_nxt_s = {lo_r[6:0], 1'b0};
    end
  end

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 3'd0;
      op_r      <= 1'b0;
      opnd_r    <= 8'h00;
      hi_r      <= 8'h00;
      lo_r      <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cy_r      <= 1'b0;
      ov_r      <= 1'b0;
      acc_out_r <= 8'h00;
      b_out_r   <= 8'h00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            op_r   <= bus.op;
            cnt_r  <= 3'd7;
            hi_r   <= 8'h00;
            busy_r <= 1'b1;
            if (bus.op) begin
              lo_r   <= bus.acc_in;
              opnd_r <= bus.b_in;
              if (bus.b_in == 8'h00) begin
                // Divide by zero: operands pass through untouched, OV flags it.
                state_r   <= ST_DONE;
                done_r    <= 1'b1;
                acc_out_r <= bus.acc_in;
                b_out_r   <= bus.b_in;
                ov_r      <= 1'b1;
                cy_r      <= 1'b0;
              end else begin
                state_r <= ST_RUN;
              end
            end else begin
              lo_r    <= bus.b_in;
              opnd_r  <= bus.acc_in;
              state_r <= ST_RUN;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          hi_r <= hi_nxt_s;
          lo_r <= lo_nxt_s;
          if (cnt_r == 3'd0) begin
            state_r   <= ST_DONE;
            done_r    <= 1'b1;
            acc_out_r <= lo_nxt_s;
            b_out_r   <= hi_nxt_s;
            ov_r      <= (op_r == 1'b0) ? (hi_nxt_s != 8'h00) : 1'b0;
            cy_r      <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.flag_we = done_r;
  assign bus.acc_out = acc_out_r;
  assign bus.b_out   = b_out_r;
  assign bus.cy_out  = cy_r;
  assign bus.ov_out  = ov_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a driver predicts results with plain arithmetic,
// a monitor pops and compares whenever done is seen.
module tb_muldiv_seq;

  logic clock = 1'b0;
  logic reset;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] acc;
    logic [7:0] b;
    logic       ov;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   start_at = -100;
  int   done_at  = -100;
  bit   mon_en   = 1'b0;

  // Counts rising edges; after edge N the counter reads N.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result of MUL AB / DIV AB; t is the edge that samples start.
  function automatic exp_t ref_model(input bit op, input logic [7:0] a, input logic [7:0] b, input int t);
    exp_t e;
    int unsigned p;
    if (!op) begin
      p     = int'(a) * int'(b);
      e.acc = p[7:0];
      e.b   = p[15:8];
      e.ov  = (p > 255);
      e.at  = t + 8;
    end else if (b == 8'h00) begin
      e.acc = a;
      e.b   = b;
      e.ov  = 1'b1;
      e.at  = t;
    end else begin
      e.acc = a / b;
      e.b   = a % b;
      e.ov  = 1'b0;
      e.at  = t + 8;
    end
    return e;
  endfunction

  // Called at a falling edge; the request is sampled at the next rising edge.
  task automatic issue(input bit op, input logic [7:0] a, input logic [7:0] b);
    int   t;
    exp_t e;
    t          = cyc + 1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.acc_in = a;
    bus.b_in   = b;
    if (t >= done_at + 2) begin
      e = ref_model(op, a, b, t);
      sb.push_back(e);
      start_at = t;
      done_at  = e.at;
    end
    @(negedge clock);
    bus.start  = 1'b0;
    bus.op     = 1'($urandom);
    bus.acc_in = 8'($urandom);
    bus.b_in   = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: busy/flag_we every cycle, scoreboard pop on each done.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (mon_en && !reset) begin
      check("busy", bus.busy, (cyc >= start_at && cyc <= done_at));
      check("flag_we", bus.flag_we, bus.done);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.at);
          check("acc_out", bus.acc_out, e.acc);
          check("b_out", bus.b_out, e.b);
          check("ov_out", bus.ov_out, e.ov);
          check("cy_out", bus.cy_out, 1'b0);
        end
      end else if (sb.size() > 0 && cyc > sb[0].at) begin
        checks++;
        errors++;
        $display("FAIL missing_done: got no done by cycle %0d expected done at %0d", cyc, sb[0].at);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int         w;
    bit         rop;
    logic [7:0] ra;
    logic [7:0] rb;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.acc_in = 8'h00;
    bus.b_in   = 8'h00;
    #2;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_flag_we", bus.flag_we, 1'b0);
    check("rst_acc_out", bus.acc_out, 8'h00);
    check("rst_b_out", bus.b_out, 8'h00);
    check("rst_cy_out", bus.cy_out, 1'b0);
    check("rst_ov_out", bus.ov_out, 1'b0);
    idle(2);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(1);

    issue(1'b0, 8'h50, 8'hA0); idle(12);
    issue(1'b0, 8'h0F, 8'h11); idle(12);
    issue(1'b0, 8'hFF, 8'hFF); idle(12);
    issue(1'b1, 8'hFB, 8'h12); idle(12);
    issue(1'b1, 8'h07, 8'h09); idle(12);
    issue(1'b1, 8'h55, 8'h00); idle(3);
    check("hold_acc_out", bus.acc_out, 8'h55);
    check("hold_ov_out", bus.ov_out, 1'b1);

    // Starts at T+4 and T+9 are dropped, T+10 is taken.
    issue(1'b0, 8'h12, 8'h34); idle(3);
    issue(1'b0, 8'hFF, 8'hFF); idle(4);
    issue(1'b1, 8'h99, 8'h03);
    issue(1'b1, 8'hC8, 8'h07); idle(12);

    // Reset in the middle of a multiply.
    issue(1'b0, 8'h50, 8'hA0); idle(4);
    reset = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_acc_out", bus.acc_out, 8'h00);
    check("midrst_b_out", bus.b_out, 8'h00);
    check("midrst_ov_out", bus.ov_out, 1'b0);
    check("midrst_cy_out", bus.cy_out, 1'b0);
    sb.delete();
    start_at = -100;
    done_at  = -100;
    @(negedge clock);
    reset = 1'b0;
    idle(20);
    issue(1'b0, 8'h9C, 8'h3D); idle(12);

    // Random traffic, including starts that land while busy.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        rop = 1'($urandom);
        ra  = 8'($urandom);
        rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        issue(rop, ra, rb);
      end else begin
        idle(1);
      end
    end

    w = 0;
    while (sb.size() > 0 && w < 40) begin
      idle(1);
      w++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d results still pending expected 0", sb.size());
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
